// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the shift-register FIFO.
// The count width helper keeps the top and any wrappers in agreement.
package fifo_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned DEFAULT_DEPTH = 8;

  // Stage registers reset to all zeros.
  localparam logic STAGE_RESET_BIT = 1'b0;

  function automatic int unsigned clog2_depth(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_stage.sv
// One WIDTH-bit FIFO stage: loads either the next stage's word or data_in.
module fifo_stage
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             sel_in,
  input  logic [WIDTH-1:0] next_data,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= {WIDTH{STAGE_RESET_BIT}};
    end else if (load) begin
      q <= sel_in ? data_in : next_data;
    end
  end

endmodule

// File: rtl/shift_reg_fifo.sv
// Show-ahead FIFO built from a chain of register stages shifting toward stage 0.
// Owns occupancy count, threshold flags, sticky errors and per-stage decode.
module shift_reg_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2,
  localparam int unsigned CW      = clog2_depth(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clr_err,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  if (DEPTH < 2 || DEPTH > 64 || AE_LEVEL >= AF_LEVEL) begin : g_bad_cfg
    $fatal(1, "shift_reg_fifo: illegal DEPTH/AE_LEVEL/AF_LEVEL combination");
  end

  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] sel_in;
  logic             push_ok;
  logic             pop_ok;

  assign full         = (count == DEPTH_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);
  assign data_out     = stage_q[0];

  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  // A pop shifts every stage (invalid ones just shift zeros); on a combined
  // push/pop the new word lands in the slot the old tail shifted out of.
  always_comb begin
    load   = '0;
    sel_in = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (pop_ok) begin
        load[i]   = 1'b1;
        sel_in[i] = push_ok && (count - CW'(1) == CW'(i));
      end else if (push_ok && (count == CW'(i))) begin
        load[i]   = 1'b1;
        sel_in[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] next_data;
    if (g == DEPTH - 1) begin : g_tail
      assign next_data = '0;
    end else begin : g_body
      assign next_data = stage_q[g+1];
    end

    fifo_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .load     (load[g]),
      .sel_in   (sel_in[g]),
      .next_data(next_data),
      .data_in  (data_in),
      .q        (stage_q[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (push_ok && !pop_ok) begin
      count <= count + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count <= count - CW'(1);
    end
  end

  // A new error in the same cycle as clr_err takes priority over the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (pop && empty) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_reg_fifo.sv
// Bench for shift_reg_fifo: queue-based reference model checked every cycle,
// directed scenarios pinned with literal expectations, then random traffic.
module tb_shift_reg_fifo;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AF    = 6;
  localparam int unsigned AE    = 2;
  localparam int unsigned CW    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] data_out;
  logic [CW-1:0]    count;
  logic             full, empty, almost_full, almost_empty, overflow, underflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] mq [$];
  logic             m_ovf = 1'b0;
  logic             m_unf = 1'b0;

  shift_reg_fifo #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .AF_LEVEL(AF),
    .AE_LEVEL(AE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .pop         (pop),
    .clr_err     (clr_err),
    .data_in     (data_in),
    .data_out    (data_out),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: a plain queue of words plus two sticky bits.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      automatic bit is_full  = (mq.size() == DEPTH);
      automatic bit is_empty = (mq.size() == 0);
      automatic bit pok = push && (!is_full || pop);
      automatic bit rok = pop && !is_empty;
      if (push && is_full && !pop) m_ovf = 1'b1;
      else if (clr_err) m_ovf = 1'b0;
      if (pop && is_empty) m_unf = 1'b1;
      else if (clr_err) m_unf = 1'b0;
      if (rok) void'(mq.pop_front());
      if (pok) mq.push_back(data_in);
    end
  end

  always @(negedge clk) begin
    automatic int n = mq.size();
    chk("data_out", 32'(data_out), (n > 0) ? 32'(mq[0]) : 32'd0);
    chk("count", 32'(count), 32'(n));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("almost_full", 32'(almost_full), 32'(n >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
  end

  task automatic cyc(input logic p, input logic o, input logic c, input logic [WIDTH-1:0] d);
    push = p; pop = o; clr_err = c; data_in = d;
    @(posedge clk);
    #2;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // Reset asserted mid-stream with 5 entries held.
    for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, 1'b0, WIDTH'(16'h50 + i));
    chk("pre_reset_count", 32'(count), 32'd5);
    #1 rst = 1'b0;
    #1;
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_overflow", 32'(overflow), 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;

    // Fill and overflow.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0, 1'b0, WIDTH'(i));
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_af", 32'(almost_full), (i >= 6) ? 32'd1 : 32'd0);
    end
    chk("fill_full", 32'(full), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 16'h0009);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd8);

    // Drain and underflow.
    for (int i = 1; i <= 8; i++) begin
      chk("drain_head", 32'(data_out), 32'(i));
      cyc(1'b0, 1'b1, 1'b0, '0);
    end
    chk("drain_empty", 32'(empty), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, '0);
    chk("unf_set", 32'(underflow), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, '0);
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_unf", 32'(underflow), 32'd0);

    // Simultaneous push/pop while full.
    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 1'b0, WIDTH'(i));
    cyc(1'b1, 1'b1, 1'b0, 16'hAAAA);
    chk("pp_full_count", 32'(count), 32'd8);
    chk("pp_full_head", 32'(data_out), 32'h0002);
    chk("pp_full_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b0, '0);
    chk("pp_full_tail", 32'(data_out), 32'hAAAA);
    cyc(1'b0, 1'b1, 1'b0, '0);
    chk("pp_full_drained", 32'(empty), 32'd1);

    // Simultaneous push/pop while empty.
    cyc(1'b1, 1'b1, 1'b0, 16'h1234);
    chk("pp_empty_count", 32'(count), 32'd1);
    chk("pp_empty_head", 32'(data_out), 32'h1234);
    chk("pp_empty_unf", 32'(underflow), 32'd1);
    cyc(1'b0, 1'b1, 1'b1, '0);

    // Error versus clear in the same cycle.
    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 1'b0, WIDTH'(16'h100 + i));
    cyc(1'b1, 1'b0, 1'b0, 16'hDEAD);
    chk("evc_ovf_set", 32'(overflow), 32'd1);
    cyc(1'b1, 1'b0, 1'b1, 16'hBEEF);
    chk("evc_set_wins", 32'(overflow), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, '0);
    chk("evc_cleared", 32'(overflow), 32'd0);
    chk("evc_count", 32'(count), 32'd8);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 15) == 0), WIDTH'($urandom));
    end
    cyc(1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
